// File: rtl/inst_pkg.sv
// Shared instruction-format definitions used by both the encoder and the
// decode stage: field widths, bit positions, format codes and helpers that
// pack fields into a 32-bit word or pull them back out again.
package inst_pkg;

  localparam int WORD_W     = 32;
  localparam int OPCODE_W   = 6;
  localparam int REG_W      = 5;
  localparam int SHAMT_W    = 5;
  localparam int FUNC_W     = 6;
  localparam int IMM_W      = 16;

  localparam int OPCODE_LSB = 26;
  localparam int RD_LSB     = 21;
  localparam int RS_LSB     = 16;
  localparam int RT_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_LSB    = 0;

  typedef enum logic {
    FMT_R = 1'b0,
    FMT_I = 1'b1
  } fmt_e;

  // Fully decoded view of one instruction word, shared with the decoder.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNC_W-1:0]   func;
    logic [WORD_W-1:0]   imm;
  } fields_t;

  // R-format: opcode | rd | rs | rt | shamt | func
  function automatic logic [WORD_W-1:0] pack_r(
    input logic [OPCODE_W-1:0] opcode,
    input logic [REG_W-1:0]    rd,
    input logic [REG_W-1:0]    rs,
    input logic [REG_W-1:0]    rt,
    input logic [SHAMT_W-1:0]  shamt,
    input logic [FUNC_W-1:0]   func
  );
    logic [WORD_W-1:0] word;
    word = '0;
    word[OPCODE_LSB +: OPCODE_W] = opcode;
    word[RD_LSB     +: REG_W]    = rd;
    word[RS_LSB     +: REG_W]    = rs;
    word[RT_LSB     +: REG_W]    = rt;
    word[SHAMT_LSB  +: SHAMT_W]  = shamt;
    word[FUNC_LSB   +: FUNC_W]   = func;
    return word;
  endfunction

  // I-format: opcode | rd | rs | imm[15:0]
  function automatic logic [WORD_W-1:0] pack_i(
    input logic [OPCODE_W-1:0] opcode,
    input logic [REG_W-1:0]    rd,
    input logic [REG_W-1:0]    rs,
    input logic [IMM_W-1:0]    imm16
  );
    logic [WORD_W-1:0] word;
    word = '0;
    word[OPCODE_LSB +: OPCODE_W] = opcode;
    word[RD_LSB     +: REG_W]    = rd;
    word[RS_LSB     +: REG_W]    = rs;
    word[IMM_LSB    +: IMM_W]    = imm16;
    return word;
  endfunction

  // A 32-bit immediate survives the 16-bit round trip only when bits 31:15
  // are a pure sign extension of bit 15.
  function automatic logic imm_in_range(input logic [WORD_W-1:0] imm);
    return (&imm[WORD_W-1:IMM_W-1]) || !(|imm[WORD_W-1:IMM_W-1]);
  endfunction

  // Decoder-side inverse of pack_r/pack_i; imm is sign-extended from bit 15.
  function automatic fields_t unpack_word(input logic [WORD_W-1:0] word);
    fields_t f;
    f.opcode = word[OPCODE_LSB +: OPCODE_W];
    f.rd     = word[RD_LSB     +: REG_W];
    f.rs     = word[RS_LSB     +: REG_W];
    f.rt     = word[RT_LSB     +: REG_W];
    f.shamt  = word[SHAMT_LSB  +: SHAMT_W];
    f.func   = word[FUNC_LSB   +: FUNC_W];
    f.imm    = {{(WORD_W-IMM_W){word[IMM_W-1]}}, word[IMM_LSB +: IMM_W]};
    return f;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding encoded instruction words between the packer and
// instruction memory. DEPTH must be a power of two (pointers wrap naturally).
// Pushes while full and pops while empty are ignored.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[rd_ptr];

  // Data array: written on push only, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs R/I-format fields into 32-bit words, queues them
// in inst_fifo and streams them to instruction memory at auto-incrementing
// word addresses. Optional immediate range checking is enabled by defining
// INST_ENCODER_RANGE_CHECK_EN; otherwise imm is silently truncated and err
// stays 0.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [SHAMT_W-1:0]  shift,
  input  logic [WORD_W-1:0]   imm,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                err,
  output logic [ADDR_W:0]     words_written
);

  localparam logic [ADDR_W:0] WW_MAX = '1;

  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              write_done;
  logic [WORD_W-1:0] enc_word;
  fmt_e              fmt;

  assign fmt        = fmt_e'(in_fmt);
  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;
  assign mem_we     = !fifo_empty;
  assign busy       = !fifo_empty;
  assign write_done = mem_we && mem_ready;

  // Field packing; I-format keeps only the low 16 bits of the immediate.
  always_comb begin
    enc_word = pack_r(opcode, rd, rs, rt, shift, func);
    if (fmt == FMT_I) begin
      enc_word = pack_i(opcode, rd, rs, imm[IMM_W-1:0]);
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (write_done),
    .din   (enc_word),
    .head  (mem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write address and saturating completed-write counter advance per write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr      <= BASE_ADDR;
      words_written <= '0;
    end else if (write_done) begin
      mem_addr <= mem_addr + 1'b1;
      if (words_written != WW_MAX) begin
        words_written <= words_written + 1'b1;
      end
    end
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  // Sticky flag set when an accepted I-format immediate loses information.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && (fmt == FMT_I) && !imm_in_range(imm)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^imm[WORD_W-1:IMM_W];
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: a scoreboard queue of expected words
// is filled on every accepted tuple and drained on every completed memory
// write. A second instance (ADDR_W 4, BASE_ADDR 14) covers address wrap.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_fmt = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  func = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  shift = '0;
  logic [31:0] imm = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        err;
  logic [8:0]  words_written;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic        w_mem_we;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_mem_ready = 1'b0;
  logic        w_busy;
  logic        w_err;
  logic [4:0]  w_words_written;

  int          vectors = 0;
  int          miscompares = 0;
  int          accepts = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_word;
  logic [7:0]  exp_addr = 8'd0;
  logic        exp_err;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .opcode(opcode), .func(func), .rd(rd), .rs(rs),
    .rt(rt), .shift(shift), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .err(err),
    .words_written(words_written)
  );

  inst_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'd14)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_fmt(in_fmt), .opcode(opcode), .func(func), .rd(rd), .rs(rs),
    .rt(rt), .shift(shift), .imm(imm), .mem_we(w_mem_we),
    .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_ready(w_mem_ready), .busy(w_busy), .err(w_err),
    .words_written(w_words_written)
  );

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one tuple and computes the word the bench expects for it.
  task automatic applyStimulus(input logic fmt, input logic [5:0] op,
                               input logic [4:0] d, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] sh,
                               input logic [5:0] fn, input logic [31:0] im);
    in_fmt   = fmt;
    opcode   = op;
    rd       = d;
    rs       = s;
    rt       = t;
    shift    = sh;
    func     = fn;
    imm      = im;
    in_valid = 1'b1;
    if (fmt) cur_word = {op, d, s, im[15:0]};
    else     cur_word = {op, d, s, t, sh, fn};
  endtask

  // One clock: record accepts and score completed writes at the negedge.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_word);
      accepts++;
    end
    if (mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", mem_wdata, 32'hxxxx_xxxx);
      end else begin
        checkOutput("wdata", mem_wdata, exp_q.pop_front());
        checkOutput("waddr", {24'd0, mem_addr}, {24'd0, exp_addr});
        exp_addr = exp_addr + 8'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr = 8'd0;
    accepts  = 0;
  endtask

  initial begin
    logic [31:0] w_words [3];
    logic [3:0]  w_addrs [3];
    int          n;

`ifdef INST_ENCODER_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Reset values
    doReset();
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("rst_words", {23'd0, words_written}, 32'd0);
    checkOutput("rst_w_mem_addr", {28'd0, w_mem_addr}, 32'd14);

    // R-format basic write
    mem_ready = 1'b1;
    applyStimulus(1'b0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("r_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("r_mem_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("r_wdata", mem_wdata, 32'h0022_1820);
    tick();
    checkOutput("r_addr_after", {24'd0, mem_addr}, 32'd1);
    checkOutput("r_words_after", {23'd0, words_written}, 32'd1);
    checkOutput("r_we_after", {31'd0, mem_we}, 32'd0);

    // I-format, negative in-range immediate
    applyStimulus(1'b1, 6'h08, 5'd5, 5'd6, 5'd31, 5'd31, 6'h3f, 32'hFFFF_FFFC);
    tick();
    in_valid = 1'b0;
    checkOutput("i_wdata", mem_wdata, 32'h20A6_FFFC);
    checkOutput("i_err", {31'd0, err}, 32'd0);
    tick();
    checkOutput("i_words_after", {23'd0, words_written}, 32'd2);

    // Backpressure: five back-to-back tuples, only four fit
    doReset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 6'(i + 1), 5'(i), 5'(i + 7), 5'(i + 9), 5'(i), 6'(i + 32), 32'd0);
      tick();
      checkOutput($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    checkOutput("bp_accepts", accepts, 32'd4);
    checkOutput("bp_busy", {31'd0, busy}, 32'd1);
    checkOutput("bp_held_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("bp_held_data", mem_wdata, {6'd1, 5'd0, 5'd7, 5'd9, 5'd0, 6'd32});
    mem_ready = 1'b1;
    tick();
    checkOutput("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    n = 0;
    while (mem_we && n < 10) begin
      tick();
      n++;
    end
    checkOutput("bp_drained", exp_q.size(), 32'd0);
    checkOutput("bp_words", {23'd0, words_written}, 32'd4);
    checkOutput("bp_final_addr", {24'd0, mem_addr}, 32'd4);

    // Address wrap on the 4-bit instance
    doReset();
    w_mem_ready = 1'b1;
    w_addrs[0] = 4'd14;
    w_addrs[1] = 4'd15;
    w_addrs[2] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      w_words[i] = {6'(i + 2), 5'd3, 5'd4, 5'd5, 5'd6, 6'(i)};
    end
    n = 0;
    applyStimulus(1'b0, 6'd2, 5'd3, 5'd4, 5'd5, 5'd6, 6'd0, 32'd0);
    in_valid   = 1'b0;
    w_in_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (w_mem_we && w_mem_ready && n < 3) begin
        checkOutput($sformatf("wrap_addr_%0d", n), {28'd0, w_mem_addr}, {28'd0, w_addrs[n]});
        checkOutput($sformatf("wrap_data_%0d", n), w_mem_wdata, w_words[n]);
        n++;
      end
      @(posedge clk);
      #1;
      if (cyc < 2) func = 6'(cyc + 1);
      else         w_in_valid = 1'b0;
      opcode = 6'(cyc + 3);
    end
    checkOutput("wrap_count", n, 32'd3);
    checkOutput("wrap_words", {27'd0, w_words_written}, 32'd3);
    checkOutput("wrap_final_addr", {28'd0, w_mem_addr}, 32'd1);
    w_mem_ready = 1'b0;

    // Immediate range check (err expectation follows the build option)
    doReset();
    mem_ready = 1'b1;
    applyStimulus(1'b1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0001_0000);
    tick();
    checkOutput("range_err", {31'd0, err}, {31'd0, exp_err});
    checkOutput("range_wdata", mem_wdata, 32'h2022_0000);
    applyStimulus(1'b0, 6'd4, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 32'd0);
    tick();
    applyStimulus(1'b1, 6'd9, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 32'hFFFF_8000);
    tick();
    in_valid = 1'b0;
    checkOutput("range_err_sticky", {31'd0, err}, {31'd0, exp_err});
    n = 0;
    while (mem_we && n < 10) begin
      tick();
      n++;
    end
    checkOutput("range_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a stalled stream
    doReset();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'(i + 10), 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("mid_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_we_async", {31'd0, mem_we}, 32'd0);
    checkOutput("mid_busy_async", {31'd0, busy}, 32'd0);
    checkOutput("mid_addr_async", {24'd0, mem_addr}, 32'd0);
    checkOutput("mid_err_async", {31'd0, err}, 32'd0);
    exp_q.delete();
    exp_addr = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    applyStimulus(1'b0, 6'd33, 5'd7, 5'd8, 5'd9, 5'd10, 6'd11, 32'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("mid_new_addr", {24'd0, mem_addr}, 32'd0);
    tick();
    checkOutput("mid_new_words", {23'd0, words_written}, 32'd1);
    checkOutput("mid_new_we", {31'd0, mem_we}, 32'd0);
    checkOutput("mid_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decode stage: packs decoded instruction fields (opcode, rd, rs, rt, shift, func, or a 32-bit immediate) into a 32-bit RISC instruction word.
- Encoded words are buffered in a small FIFO and streamed into instruction memory at auto-incrementing word addresses.
- Used by the program loader and by test benches that build programs field by field.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  field tuple valid
in_ready  out  1  encoder can accept a tuple
in_fmt  in  1  0 = R-format, 1 = I-format
opcode  in  6  opcode field
func  in  6  function field (R only)
rd  in  5  destination register
rs  in  5  source register
rt  in  5  operand register (R only)
shift  in  5  shift amount (R only)
imm  in  32  signed immediate (I only)
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  word address of mem_wdata
mem_wdata  out  32  encoded instruction word
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  FIFO non-empty
err  out  1  sticky immediate-range error
words_written  out  ADDR_W+1  saturating count of completed writes

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: FIFO empty, rd/wr pointers 0, mem_addr = BASE_ADDR, mem_we 0, busy 0, err 0, words_written 0, in_ready 1.
- Packing, R-format: word = {opcode[31:26], rd[25:21], rs[20:16], rt[15:11], shift[10:6], func[5:0]}.
- Packing, I-format: word = {opcode, rd, rs, imm[15:0]}. rt, shift and func are ignored.
- Round trip: decode sign-extends bits 15:0 back to imm.
- Input handshake:
  - in_ready = !full, combinational from the occupancy count.
  - A tuple is accepted on a rising edge where in_valid && in_ready; the encoded word is written to the FIFO at that edge.
  - Inputs are don't-care when in_valid = 0.
- Output handshake:
  - mem_we = !empty; mem_wdata = FIFO head; mem_addr is a register.
  - A write completes on an edge with mem_we && mem_ready. At that edge: pop, mem_addr += 1, words_written += 1 (saturates at all-ones).
  - While mem_ready = 0, mem_we, mem_addr and mem_wdata are held stable.
- Latency: a tuple accepted at edge N is presented on mem_wdata in the cycle after N when the FIFO was empty. There is no bypass path.
- Simultaneous push and pop: allowed whenever not full; occupancy is unchanged. When full, in_ready = 0, so a pop alone frees a slot that is visible the next cycle.
- Empty: mem_we = 0 and mem_wdata is don't-care.
- Wrap: mem_addr wraps from 2^ADDR_W − 1 to 0 with no flag.
- Reset mid-operation: FIFO contents are discarded. mem_we drops immediately (asynchronous), and mem_addr returns to BASE_ADDR.
- busy = !empty.

Optional Feature:
- Macro INST_ENCODER_RANGE_CHECK_EN.
- Defined:
  - An I-format tuple is in range if imm[31:15] is all-0 or all-1.
  - An out-of-range tuple is still accepted and written truncated, and sets err on the accept edge.
  - err is sticky until rst.
- Undefined: no check is made; imm is silently truncated to bits 15:0 and err is tied to 0.

Decomposition:
- Shared package inst_pkg holds:
  - field widths (OPCODE_W = 6, REG_W = 5, SHAMT_W = 5, FUNC_W = 6, IMM_W = 16);
  - bit positions (OPCODE_LSB = 26, RD_LSB = 21, RS_LSB = 16, RT_LSB = 11, SHAMT_LSB = 6);
  - format codes FMT_R = 0 and FMT_I = 1.
- The decode stage should consume the same package.
- One sub-module, inst_fifo: a synchronous FIFO with parameterised DEPTH and width 32, exposing full, empty, push, pop and head. The encoder keeps packing, the address counter and error logic.

Test Plan:
- R-format opcode 0, rd 1, rs 2, rt 3, shift 0, func 0x20, mem_ready 1 → next cycle mem_we = 1, mem_addr = 0, mem_wdata = 0x00221820; following cycle mem_addr = 1, words_written = 1.
- I-format opcode 0x08, rd 5, rs 6, imm −4 → mem_wdata = 0x20A6FFFC, err stays 0.
- Backpressure: mem_ready 0, push 5 back-to-back tuples → in_ready drops after the 4th accept and only 4 are stored. Then mem_ready 1 → 4 writes at addresses 0–3 in order, in_ready returns to 1 the cycle after the first pop.
- Wrap: ADDR_W 4, BASE_ADDR 14, push 3 words → writes at addresses 14, 15, 0.
- With INST_ENCODER_RANGE_CHECK_EN, I-format imm 0x00010000 → word low half 0x0000 written, err = 1 and held across later valid tuples. Without the macro → err = 0.
- Reset mid-stream: 3 entries queued, mem_ready 0, assert rst between edges → mem_we = 0 immediately, busy 0, mem_addr = BASE_ADDR. After release, the first new tuple is written at BASE_ADDR.
